fetch_mem_arbiter: RTL and testbench
====================================

Name: fetch_mem_arbiter

Overview:
Shares one single-port unified memory between the instruction-fetch stage (read-only, 32-bit instructions) and the memory stage (64-bit loads/stores). Uses a three-phase FSM per access (arbitrate, memory busy, response) with data-priority arbitration and an anti-starvation counter for fetch. Supports branch-flush cancellation of an in-flight fetch. Sits between the IF/MEM pipeline stages and the shared memory model.

Parameters:
ADDR_W, 64, byte address width for both requesters and memory
DATA_W, 64, memory and data-port width (fixed 64; instruction lane select assumes this)
STARVE_LIMIT, 4, consecutive data grants allowed while if_req is pending before fetch is forced (>=1)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
if_req  in  1  fetch request; level, held with if_addr stable until if_ack
if_addr  in  ADDR_W  fetch byte address (word-aligned)
if_flush  in  1  branch redirect pulse; cancels the in-flight fetch
if_ack  out  1  one-cycle fetch completion pulse
if_instr  out  32  fetched instruction, valid when if_ack=1
d_req  in  1  data request; level, held with d_* stable until d_ack
d_we  in  1  1=store, 0=load
d_addr  in  ADDR_W  data byte address
d_wdata  in  DATA_W  store data
d_be  in  8  store byte enables
d_ack  out  1  one-cycle data completion pulse
d_rdata  out  DATA_W  load data, valid when d_ack=1
mem_req  out  1  memory access active
mem_we  out  1  memory write enable
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_be  out  8  memory byte enables
mem_rdata  in  DATA_W  memory read data, sampled when mem_ready=1
mem_ready  in  1  memory completes the current access this cycle (latency >=0 cycles after mem_req rises)

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D.
- IDLE: arbitrate. d_req&!if_req -> BUSY_D; if_req&!d_req -> BUSY_I; both: BUSY_I if streak==STARVE_LIMIT, else BUSY_D. No request -> stay IDLE. On transition, register the winner's address, we, wdata, be (fetch: we=0, be=0).
- Starvation counter streak: +1 on each data grant made while if_req=1 (saturates at STARVE_LIMIT); cleared on fetch grant or on any IDLE cycle with if_req=0.
- BUSY_x: mem_req=1 with registered fields stable. Stay until mem_ready=1, then capture mem_rdata and move to RESP_x.
- RESP_D: d_ack=1, d_rdata=captured data (stores: d_rdata=0) -> IDLE.
- RESP_I: if_instr = captured[63:32] if registered addr[2]=1, else captured[31:0]. if_ack = !killed & !if_flush -> IDLE.
- killed flag: set when if_flush=1 in BUSY_I; cleared on entering IDLE. The memory access is never aborted; a killed fetch completes silently with no if_ack. if_flush in IDLE/BUSY_D/RESP_D: no effect on the arbiter.
- Requester rule: requesters drop or update req on the cycle after ack. Because IDLE follows RESP, no duplicate grant occurs. Minimum latency: req seen in IDLE at cycle 0, mem_ready at cycle 1, ack at cycle 2; throughput is 1 access per 3 cycles.
- mem_* outputs are 0 whenever mem_req=0. mem_req is decoded from state only; no combinational path from requests to memory.
- Reset (any state, including mid-access): state=IDLE, streak=0, killed=0, all registers and outputs 0. The memory must tolerate mem_req dropping mid-access.
- Address misalignment is not checked.

Test Plan:
- Single fetch: if_req=1, if_addr=0x4, mem_ready at 1st busy cycle with mem_rdata=0xAAAA_BBBB_CCCC_DDDD -> mem_req cycle 1, if_ack cycle 2, if_instr=0xAAAABBBB.
- Store: d_req, d_we=1, d_addr=0x40, d_wdata=0x1122334455667788, d_be=0xFF, mem_ready after 3 wait cycles -> mem_we=1 and fields stable for 4 cycles, then d_ack=1 with d_rdata=0.
- Contention: if_req and d_req both held continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I; if_ack every 5th access.
- Flush: during BUSY_I with mem_ready delayed 2 cycles, pulse if_flush -> the access completes with mem_req for 3 cycles, RESP_I has if_ack=0, FSM returns to IDLE.
- Reset mid-access: assert reset in BUSY_D -> next cycle mem_req=0, d_ack=0, state IDLE; a fresh d_req after reset is served normally.
- Back-to-back loads with a requester that drops req on the ack+1 cycle -> exactly one d_ack per request, with no duplicate mem_req.

Source files
------------

// File: rtl/fetch_mem_arbiter.sv
// fetch_mem_arbiter: shares one single-port memory between instruction fetch and the data stage,
// data-priority with a starvation guard for fetch and silent completion of flushed fetches.
module fetch_mem_arbiter #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_ack,
   output logic [31:0]       if_instr,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [7:0]        d_be,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [7:0]        mem_be,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);

   typedef enum logic [2:0] {IDLE, BUSY_I, BUSY_D, RESP_I, RESP_D} state_t;

   state_t            state_q, state_d;
   logic [SW-1:0]     streak_q, streak_d;
   logic              killed_q, killed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              we_q, we_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [7:0]        be_q, be_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              busy;

   always_comb begin
      state_d  = state_q;
      streak_d = streak_q;
      killed_d = killed_q;
      addr_d   = addr_q;
      we_d     = we_q;
      wdata_d  = wdata_q;
      be_d     = be_q;
      rdata_d  = rdata_q;
      case (state_q)
         IDLE: begin
            // data wins unless fetch has waited through LIM data grants; streak < LIM here when if_req
            if (d_req && !(if_req && streak_q == LIM)) begin
               state_d  = BUSY_D;
               addr_d   = d_addr;
               we_d     = d_we;
               wdata_d  = d_wdata;
               be_d     = d_be;
               streak_d = if_req ? streak_q + 1'b1 : '0;
            end else if (if_req) begin
               state_d  = BUSY_I;
               addr_d   = if_addr;
               we_d     = 1'b0;
               wdata_d  = '0;
               be_d     = '0;
               streak_d = '0;
            end else begin
               streak_d = '0;
            end
         end
         BUSY_I: begin
            if (if_flush) killed_d = 1'b1;
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = RESP_I;
            end
         end
         BUSY_D: begin
            if (mem_ready) begin
               rdata_d = mem_rdata;
               state_d = RESP_D;
            end
         end
         default: begin
            state_d  = IDLE;
            killed_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         streak_q <= '0;
         killed_q <= 1'b0;
         addr_q   <= '0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         be_q     <= '0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         streak_q <= streak_d;
         killed_q <= killed_d;
         addr_q   <= addr_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         be_q     <= be_d;
         rdata_q  <= rdata_d;
      end
   end

   assign busy      = state_q == BUSY_I || state_q == BUSY_D;
   assign mem_req   = busy;
   assign mem_we    = busy & we_q;
   assign mem_addr  = busy ? addr_q : '0;
   assign mem_wdata = busy ? wdata_q : '0;
   assign mem_be    = busy ? be_q : '0;
   assign if_ack    = state_q == RESP_I && !killed_q && !if_flush;
   assign if_instr  = state_q == RESP_I ? (addr_q[2] ? rdata_q[63:32] : rdata_q[31:0]) : '0;
   assign d_ack     = state_q == RESP_D;
   assign d_rdata   = d_ack && !we_q ? rdata_q : '0;
endmodule

// File: tb/tb_fetch_mem_arbiter.sv
// tb_fetch_mem_arbiter: directed bench for fetch_mem_arbiter against a small latency-programmable memory.
module tb_fetch_mem_arbiter;
   logic        clk = 1'b0;
   logic        reset;
   logic        if_req, if_flush, if_ack;
   logic [63:0] if_addr;
   logic [31:0] if_instr;
   logic        d_req, d_we, d_ack;
   logic [63:0] d_addr, d_wdata, d_rdata;
   logic [7:0]  d_be;
   logic        mem_req, mem_we, mem_ready;
   logic [63:0] mem_addr, mem_wdata, mem_rdata;
   logic [7:0]  mem_be;

   int checks = 0;
   int errors = 0;
   int lat = 0;
   int cnt = 0;
   int dack_cnt = 0;
   int mreq_rises = 0;
   logic mreq_prev = 1'b0;
   logic [63:0] mem [32];

   fetch_mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_LIMIT(4)) dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_ack(if_ack), .if_instr(if_instr),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   assign mem_ready = mem_req && (cnt == lat);
   assign mem_rdata = mem[mem_addr[7:3]];

   always @(posedge clk) begin
      cnt <= (mem_req && !mem_ready) ? cnt + 1 : 0;
      if (mem_req && mem_ready && mem_we)
         for (int b = 0; b < 8; b++)
            if (mem_be[b]) mem[mem_addr[7:3]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      if (d_ack) dack_cnt <= dack_cnt + 1;
      if (mem_req && !mreq_prev) mreq_rises <= mreq_rises + 1;
      mreq_prev <= mem_req;
   end

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 64'(i) * 64'h0101_0101_0101_0101;
      mem[0] = 64'hAAAA_BBBB_CCCC_DDDD;
      mem[1] = 64'h5555_6666_7777_8888;
      mem[2] = 64'h0123_4567_89AB_CDEF;
      reset = 1'b1; if_req = 0; if_addr = 0; if_flush = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
      repeat (3) cyc();
      chk("rst_mem_req", 64'(mem_req), 0);
      chk("rst_acks", {62'b0, if_ack, d_ack}, 0);
      chk("rst_mem_addr", mem_addr, 0);
      reset = 1'b0;
      cyc();

      // single fetch, upper instruction lane
      if_req = 1; if_addr = 64'h4;
      chk("f_idle_mem_req", 64'(mem_req), 0);
      cyc();
      chk("f_busy_mem_req", 64'(mem_req), 1);
      chk("f_busy_addr", mem_addr, 64'h4);
      chk("f_busy_we", 64'(mem_we), 0);
      cyc();
      chk("f_ack", 64'(if_ack), 1);
      chk("f_instr", 64'(if_instr), 64'hAAAABBBB);
      chk("f_resp_mem_req", 64'(mem_req), 0);
      if_req = 0;
      cyc();
      chk("f_idle_ack", 64'(if_ack), 0);

      // store with three wait cycles
      lat = 3; d_req = 1; d_we = 1; d_addr = 64'h40; d_wdata = 64'h1122334455667788; d_be = 8'hFF;
      for (int k = 0; k < 4; k++) begin
         cyc();
         chk("st_mem_req", 64'(mem_req), 1);
         chk("st_fields", {mem_we, mem_be, mem_addr[7:0]}, {1'b1, 8'hFF, 8'h40});
         chk("st_wdata", mem_wdata, 64'h1122334455667788);
         chk("st_no_ack", 64'(d_ack), 0);
      end
      cyc();
      chk("st_ack", 64'(d_ack), 1);
      chk("st_rdata", d_rdata, 0);
      d_req = 0;
      cyc();
      lat = 0; d_req = 1; d_we = 0;
      cyc();
      chk("ld_we", 64'(mem_we), 0);
      cyc();
      chk("ld_ack", 64'(d_ack), 1);
      chk("ld_rdata", d_rdata, 64'h1122334455667788);
      d_req = 0;
      cyc();

      // contention: D,D,D,D,I repeating
      if_req = 1; if_addr = 64'h8; d_req = 1; d_we = 0; d_addr = 64'h10;
      for (int k = 0; k < 10; k++) begin
         cyc();
         chk("ct_grant_is_fetch", 64'(mem_addr == 64'h8), 64'(k % 5 == 4));
         cyc();
         chk("ct_if_ack", 64'(if_ack), 64'(k % 5 == 4));
         chk("ct_d_ack", 64'(d_ack), 64'(k % 5 != 4));
         if (k % 5 == 4) chk("ct_instr", 64'(if_instr), 64'h77778888);
         else chk("ct_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
         if (k == 9) begin if_req = 0; d_req = 0; end
         cyc();
      end

      // flush during a fetch with two wait cycles
      lat = 2; if_req = 1; if_addr = 64'h8;
      cyc();
      chk("fl_busy0", 64'(mem_req), 1);
      if_flush = 1;
      cyc();
      if_flush = 0;
      chk("fl_busy1", 64'(mem_req), 1);
      cyc();
      chk("fl_busy2", 64'(mem_req), 1);
      cyc();
      chk("fl_resp_ack", 64'(if_ack), 0);
      chk("fl_resp_mem_req", 64'(mem_req), 0);
      if_req = 0;
      cyc();
      chk("fl_idle", {62'b0, if_ack, mem_req}, 0);
      lat = 0; if_req = 1;
      cyc();
      cyc();
      chk("fl_refetch_ack", 64'(if_ack), 1);
      chk("fl_refetch_instr", 64'(if_instr), 64'h77778888);
      if_req = 0;
      cyc();

      // reset while a load is outstanding
      lat = 5; d_req = 1; d_we = 0; d_addr = 64'h10;
      cyc();
      chk("rm_busy", 64'(mem_req), 1);
      reset = 1;
      cyc();
      chk("rm_after", {62'b0, mem_req, d_ack}, 0);
      reset = 0; lat = 0;
      cyc();
      chk("rm_fresh_busy", {mem_req, mem_addr[7:0]}, {1'b1, 8'h10});
      cyc();
      chk("rm_fresh_ack", 64'(d_ack), 1);
      chk("rm_fresh_rdata", d_rdata, 64'h0123_4567_89AB_CDEF);
      d_req = 0;
      cyc();

      // back-to-back loads, requester updates on the cycle after ack
      dack_cnt = 0; mreq_rises = 0;
      d_req = 1; d_addr = 64'h10;
      cyc();
      cyc();
      chk("bb_ack0", d_rdata, 64'h0123_4567_89AB_CDEF);
      cyc();
      d_addr = 64'h18;
      cyc();
      cyc();
      chk("bb_ack1", d_rdata, 64'h0303_0303_0303_0303);
      cyc();
      d_req = 0;
      repeat (4) cyc();
      chk("bb_dack_cnt", 64'(dack_cnt), 2);
      chk("bb_mreq_rises", 64'(mreq_rises), 2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
